pic_rw_sequencer: RTL and testbench

//  Clocked, parametrised 8259 read/write control logic. Synchronises the raw CPU strobes
//  (CS_n, RD_n, WR_n, A0) and the write data, and decodes each completed write into ICW1..ICW4
//  or OCW1..OCW3. Skips ICW3 and ICW4 according to ICW1. Selects the register the CPU reads.

---
 rtl/pic_rw_sequencer_if.sv | 51 +++++
 rtl/pic_rw_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_pic_rw_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pic_rw_sequencer_if.sv
// ---------------------------------------------------------------------------
// pic_rw_sequencer_if
// Purpose : bundles the raw 8259 CPU strobes with the decoded command-word and
//           read-select outputs of pic_rw_sequencer.
// Signals : CS_n, RD_n, WR_n, A0, din        - CPU bus (driven by master)
//           wr_pulse, wr_type, wr_nr, wr_data - accepted command word
//           init_done, sngl, ic4              - initialisation status
//           rd_sel, oe                        - read register select / bus drive
//           err (only with RWSEQ_ERR_EN)      - rejected write indication
// Modports: master = CPU / bus-buffer side, slave = the sequencer.
// ---------------------------------------------------------------------------
interface pic_rw_sequencer_if #(
    parameter int DATA_W = 8
);
    logic              CS_n;
    logic              RD_n;
    logic              WR_n;
    logic              A0;
    logic [DATA_W-1:0] din;

    logic              wr_pulse;
    logic              wr_type;
    logic [1:0]        wr_nr;
    logic [DATA_W-1:0] wr_data;
    logic              init_done;
    logic              sngl;
    logic              ic4;
    logic [1:0]        rd_sel;
    logic              oe;
`ifdef RWSEQ_ERR_EN
    logic              err;
`endif

    modport master (
`ifdef RWSEQ_ERR_EN
        input  err,
`endif
        output CS_n, RD_n, WR_n, A0, din,
        input  wr_pulse, wr_type, wr_nr, wr_data,
        input  init_done, sngl, ic4, rd_sel, oe
    );

    modport slave (
`ifdef RWSEQ_ERR_EN
        output err,
`endif
        input  CS_n, RD_n, WR_n, A0, din,
        output wr_pulse, wr_type, wr_nr, wr_data,
        output init_done, sngl, ic4, rd_sel, oe
    );
endinterface

// File: rtl/pic_rw_sequencer.sv
// ---------------------------------------------------------------------------
// pic_rw_sequencer
// Purpose : clocked 8259 read/write control. Synchronises the CPU strobes and
//           write data, decodes every completed write into ICW1..ICW4 or
//           OCW1..OCW3 (skipping ICW3/ICW4 as ICW1 requests), emits a one-cycle
//           wr_pulse per accepted word and selects the register the CPU reads.
// Ports   : clk   - system clock
//           reset - synchronous, active-high reset
//           bus   - pic_rw_sequencer_if.slave (CPU strobes in, decode out)
// Params  : DATA_W       data width, bits [7:0] decoded, rest passed to wr_data
//           SYNC_STAGES  synchroniser depth (>= 2)
//           REQUIRE_INIT 1: OCWs ignored until init_done
// Option  : RWSEQ_ERR_EN - when defined, bus.err pulses (aligned with where
//           wr_pulse would be) for an A0=0/D4=0 write during ICW2..4 and for an
//           OCW blocked by REQUIRE_INIT.
// ---------------------------------------------------------------------------
module pic_rw_sequencer #(
    parameter int DATA_W       = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int REQUIRE_INIT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    pic_rw_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        S_READY = 2'd0,
        S_ICW2  = 2'd1,
        S_ICW3  = 2'd2,
        S_ICW4  = 2'd3
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] cs_chain;
    logic [SYNC_STAGES-1:0] rd_chain;
    logic [SYNC_STAGES-1:0] wr_chain;
    logic [SYNC_STAGES-1:0] a0_chain;
    logic [DATA_W-1:0]      din_chain [SYNC_STAGES];

    logic cs_s, rd_s, wr_s, a0_s;
    logic wr_d;
    logic cap_cs_n;
    logic cap_a0;
    logic [DATA_W-1:0] cap_data;
    logic ris;

    logic wr_valid;
    logic is_icw1;
    logic ocw_ok;

    assign cs_s = cs_chain[SYNC_STAGES-1];
    assign rd_s = rd_chain[SYNC_STAGES-1];
    assign wr_s = wr_chain[SYNC_STAGES-1];
    assign a0_s = a0_chain[SYNC_STAGES-1];

    // A write completes on the synchronised WR_n rising edge; the word, A0
    // and chip select were frozen in the last sample that still had WR_n low.
    assign wr_valid = wr_s & ~wr_d & ~cap_cs_n;
    assign is_icw1  = ~cap_a0 & cap_data[4];
    assign ocw_ok   = (REQUIRE_INIT == 0) || bus.init_done;

    // Strobe synchronisers. Strobes reset to their inactive level so that a
    // write in flight at reset can never produce a rising edge afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_chain <= '1;
            rd_chain <= '1;
            wr_chain <= '1;
            a0_chain <= '0;
            wr_d     <= 1'b1;
            cap_cs_n <= 1'b1;
            cap_a0   <= 1'b0;
        end else begin
            cs_chain <= {cs_chain[SYNC_STAGES-2:0], bus.CS_n};
            rd_chain <= {rd_chain[SYNC_STAGES-2:0], bus.RD_n};
            wr_chain <= {wr_chain[SYNC_STAGES-2:0], bus.WR_n};
            a0_chain <= {a0_chain[SYNC_STAGES-2:0], bus.A0};
            wr_d     <= wr_s;
            if (!wr_s) begin
                cap_cs_n <= cs_s;
                cap_a0   <= a0_s;
            end
        end
    end

    // Write data path: no reset needed, it is only consumed with a valid edge.
    always_ff @(posedge clk) begin
        din_chain[0] <= bus.din;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            din_chain[i] <= din_chain[i-1];
        end
        if (!wr_s) begin
            cap_data <= din_chain[SYNC_STAGES-1];
        end
    end

    // Command decode FSM with registered outputs; the pulse and the next
    // state for a write are committed on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_READY;
            bus.wr_pulse  <= 1'b0;
            bus.wr_type   <= 1'b0;
            bus.wr_nr     <= 2'd0;
            bus.wr_data   <= '0;
            bus.init_done <= 1'b0;
            bus.sngl      <= 1'b0;
            bus.ic4       <= 1'b0;
            bus.rd_sel    <= 2'd0;
            bus.oe        <= 1'b0;
            ris           <= 1'b0;
`ifdef RWSEQ_ERR_EN
            bus.err       <= 1'b0;
`endif
        end else begin
            bus.wr_pulse <= 1'b0;
`ifdef RWSEQ_ERR_EN
            bus.err      <= 1'b0;
`endif
            // The write has priority: a simultaneous write keeps WR_n low and
            // therefore holds oe off.
            bus.oe     <= ~cs_s & ~rd_s & wr_s;
            bus.rd_sel <= a0_s ? 2'd2 : {1'b0, ris};

            if (wr_valid) begin
                if (is_icw1) begin
                    // ICW1 restarts initialisation from any state.
                    bus.wr_pulse  <= 1'b1;
                    bus.wr_type   <= 1'b1;
                    bus.wr_nr     <= 2'd0;
                    bus.wr_data   <= cap_data;
                    bus.sngl      <= cap_data[1];
                    bus.ic4       <= cap_data[0];
                    bus.init_done <= 1'b0;
                    ris           <= 1'b0;
                    state         <= S_ICW2;
                end else begin
                    case (state)
                        S_ICW2: begin
                            if (cap_a0) begin
                                bus.wr_pulse <= 1'b1;
                                bus.wr_type  <= 1'b1;
                                bus.wr_nr    <= 2'd1;
                                bus.wr_data  <= cap_data;
                                if (!bus.sngl) begin
                                    state <= S_ICW3;
                                end else if (bus.ic4) begin
                                    state <= S_ICW4;
                                end else begin
                                    state         <= S_READY;
                                    bus.init_done <= 1'b1;
                                end
                            end else begin
`ifdef RWSEQ_ERR_EN
                                bus.err <= 1'b1;
`endif
                            end
                        end
                        S_ICW3: begin
                            if (cap_a0) begin
                                bus.wr_pulse <= 1'b1;
                                bus.wr_type  <= 1'b1;
                                bus.wr_nr    <= 2'd2;
                                bus.wr_data  <= cap_data;
                                if (bus.ic4) begin
                                    state <= S_ICW4;
                                end else begin
                                    state         <= S_READY;
                                    bus.init_done <= 1'b1;
                                end
                            end else begin
`ifdef RWSEQ_ERR_EN
                                bus.err <= 1'b1;
`endif
                            end
                        end
                        S_ICW4: begin
                            if (cap_a0) begin
                                bus.wr_pulse  <= 1'b1;
                                bus.wr_type   <= 1'b1;
                                bus.wr_nr     <= 2'd3;
                                bus.wr_data   <= cap_data;
                                bus.init_done <= 1'b1;
                                state         <= S_READY;
                            end else begin
`ifdef RWSEQ_ERR_EN
                                bus.err <= 1'b1;
`endif
                            end
                        end
                        default: begin
                            if (ocw_ok) begin
                                bus.wr_pulse <= 1'b1;
                                bus.wr_type  <= 1'b0;
                                bus.wr_data  <= cap_data;
                                if (cap_a0) begin
                                    bus.wr_nr <= 2'd0;
                                end else if (!cap_data[3]) begin
                                    bus.wr_nr <= 2'd1;
                                end else begin
                                    bus.wr_nr <= 2'd2;
                                    // OCW3 read-register command: RR selects, RIS picks ISR/IRR.
                                    if (cap_data[1]) begin
                                        ris <= cap_data[0];
                                    end
                                end
                            end else begin
`ifdef RWSEQ_ERR_EN
                                bus.err <= 1'b1;
`endif
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_pic_rw_sequencer.sv
module tb_pic_rw_sequencer;

    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pic_rw_sequencer_if #(.DATA_W(DATA_W)) bus ();

    pic_rw_sequencer #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES),
        .REQUIRE_INIT(1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;
    int err_cnt   = 0;
    logic       last_type;
    logic [1:0] last_nr;
    logic [7:0] last_data;

    // Record every output pulse, sampled just after the active edge.
    always begin
        @(posedge clk);
        #1;
        if (bus.wr_pulse === 1'b1) begin
            pulse_cnt++;
            last_type = bus.wr_type;
            last_nr   = bus.wr_nr;
            last_data = bus.wr_data;
        end
`ifdef RWSEQ_ERR_EN
        if (bus.err === 1'b1) err_cnt++;
`endif
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cpu_write(input logic a0, input logic [7:0] d, input logic cs_n,
                             input logic with_rd, output int lat);
        @(negedge clk);
        bus.A0   = a0;
        bus.din  = d;
        bus.CS_n = cs_n;
        bus.WR_n = 1'b0;
        bus.RD_n = ~with_rd;
        repeat (5) @(negedge clk);
        if (with_rd) check_val("oe_rd_wr_overlap", 32'(bus.oe), 32'd0);
        bus.WR_n = 1'b1;
        bus.RD_n = 1'b1;
        lat = 0;
        for (int i = 1; i <= SYNC_STAGES + 6; i++) begin
            @(posedge clk);
            #1;
            if (bus.wr_pulse === 1'b1 && lat == 0) lat = i;
        end
        bus.CS_n = 1'b1;
    endtask

    task automatic wr_expect(input string tag, input logic a0, input logic [7:0] d,
                             input logic exp_pulse, input logic exp_type, input logic [1:0] exp_nr);
        int p0;
        int lat;
        p0 = pulse_cnt;
        cpu_write(a0, d, 1'b0, 1'b0, lat);
        check_val({tag, "_pulse"}, 32'(pulse_cnt - p0), 32'(exp_pulse));
        if (exp_pulse) begin
            check_val({tag, "_type"}, 32'(last_type), 32'(exp_type));
            check_val({tag, "_nr"},   32'(last_nr),   32'(exp_nr));
            check_val({tag, "_data"}, 32'(last_data), 32'(d));
        end
    endtask

    task automatic cpu_read(input string tag, input logic a0, input logic [1:0] exp_sel);
        @(negedge clk);
        bus.A0   = a0;
        bus.CS_n = 1'b0;
        bus.RD_n = 1'b0;
        repeat (5) @(negedge clk);
        check_val({tag, "_oe"},     32'(bus.oe),     32'd1);
        check_val({tag, "_rd_sel"}, 32'(bus.rd_sel), 32'(exp_sel));
        bus.RD_n = 1'b1;
        bus.CS_n = 1'b1;
        repeat (5) @(negedge clk);
        check_val({tag, "_oe_off"}, 32'(bus.oe), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_wr_pulse"},  32'(bus.wr_pulse),  32'd0);
        check_val({tag, "_wr_type"},   32'(bus.wr_type),   32'd0);
        check_val({tag, "_wr_nr"},     32'(bus.wr_nr),     32'd0);
        check_val({tag, "_wr_data"},   32'(bus.wr_data),   32'd0);
        check_val({tag, "_init_done"}, 32'(bus.init_done), 32'd0);
        check_val({tag, "_sngl"},      32'(bus.sngl),      32'd0);
        check_val({tag, "_ic4"},       32'(bus.ic4),       32'd0);
        check_val({tag, "_rd_sel"},    32'(bus.rd_sel),    32'd0);
        check_val({tag, "_oe"},        32'(bus.oe),        32'd0);
`ifdef RWSEQ_ERR_EN
        check_val({tag, "_err"},       32'(bus.err),       32'd0);
`endif
    endtask

    initial begin
        int lat;
        int p0;
        int e0;
        reset    = 1'b1;
        bus.CS_n = 1'b1;
        bus.RD_n = 1'b1;
        bus.WR_n = 1'b1;
        bus.A0   = 1'b0;
        bus.din  = '0;
        repeat (4) @(negedge clk);
        check_reset_state("por");
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_state("idle");

        // OCW before initialisation is blocked
        e0 = err_cnt;
        wr_expect("ocw_pre_init", 1'b1, 8'h55, 1'b0, 1'b0, 2'd0);
`ifdef RWSEQ_ERR_EN
        check_val("ocw_pre_init_err", 32'(err_cnt - e0), 32'd1);
`endif

        // Single, ICW4 needed: ICW3 skipped
        wr_expect("t1_icw1", 1'b0, 8'h13, 1'b1, 1'b1, 2'd0);
        check_val("t1_sngl", 32'(bus.sngl), 32'd1);
        check_val("t1_ic4",  32'(bus.ic4),  32'd1);
        wr_expect("t1_icw2", 1'b1, 8'h08, 1'b1, 1'b1, 2'd1);
        check_val("t1_init_mid", 32'(bus.init_done), 32'd0);
        wr_expect("t1_icw4", 1'b1, 8'h01, 1'b1, 1'b1, 2'd3);
        check_val("t1_init_done", 32'(bus.init_done), 32'd1);

        // Operation command words and reads
        wr_expect("t3_ocw1", 1'b1, 8'hFF, 1'b1, 1'b0, 2'd0);
        wr_expect("t3_ocw2", 1'b0, 8'h20, 1'b1, 1'b0, 2'd1);
        wr_expect("t3_ocw3", 1'b0, 8'h0B, 1'b1, 1'b0, 2'd2);
        cpu_read("t3_read_isr", 1'b0, 2'd1);
        cpu_read("t3_read_imr", 1'b1, 2'd2);
        wr_expect("t3_ocw3_norr", 1'b0, 8'h08, 1'b1, 1'b0, 2'd2);
        cpu_read("t3_read_isr_kept", 1'b0, 2'd1);
        wr_expect("t3_ocw3_irr", 1'b0, 8'h0A, 1'b1, 1'b0, 2'd2);
        cpu_read("t3_read_irr", 1'b0, 2'd0);

        // Latency, chip-select gating, read/write overlap
        p0 = pulse_cnt;
        cpu_write(1'b1, 8'h3C, 1'b0, 1'b0, lat);
        check_val("t6_latency", 32'(lat), 32'(SYNC_STAGES + 1));
        check_val("t6_latency_pulse", 32'(pulse_cnt - p0), 32'd1);
        p0 = pulse_cnt;
        cpu_write(1'b1, 8'h3C, 1'b1, 1'b0, lat);
        check_val("t6_cs_high_pulse", 32'(pulse_cnt - p0), 32'd0);
        p0 = pulse_cnt;
        cpu_write(1'b1, 8'hAA, 1'b0, 1'b1, lat);
        check_val("t6_overlap_pulse", 32'(pulse_cnt - p0), 32'd1);
        check_val("t6_overlap_nr",    32'(last_nr),   32'd0);
        check_val("t6_overlap_data",  32'(last_data), 32'hAA);

        // Cascade init: all four ICWs
        wr_expect("t2_icw1", 1'b0, 8'h11, 1'b1, 1'b1, 2'd0);
        check_val("t2_ris_cleared_sel", 32'(bus.init_done), 32'd0);
        wr_expect("t2_icw2", 1'b1, 8'h20, 1'b1, 1'b1, 2'd1);
        wr_expect("t2_icw3", 1'b1, 8'h04, 1'b1, 1'b1, 2'd2);
        wr_expect("t2_icw4", 1'b1, 8'h01, 1'b1, 1'b1, 2'd3);
        check_val("t2_init_done", 32'(bus.init_done), 32'd1);

        // ICW1 restart from S_ICW3, and a stray A0=0/D4=0 word mid-sequence
        wr_expect("t4_icw1", 1'b0, 8'h11, 1'b1, 1'b1, 2'd0);
        wr_expect("t4_icw2", 1'b1, 8'h20, 1'b1, 1'b1, 2'd1);
        e0 = err_cnt;
        wr_expect("t4_stray", 1'b0, 8'h05, 1'b0, 1'b0, 2'd0);
`ifdef RWSEQ_ERR_EN
        check_val("t4_stray_err", 32'(err_cnt - e0), 32'd1);
`endif
        wr_expect("t4_restart", 1'b0, 8'h10, 1'b1, 1'b1, 2'd0);
        check_val("t4_restart_init", 32'(bus.init_done), 32'd0);
        check_val("t4_restart_sngl", 32'(bus.sngl), 32'd0);
        check_val("t4_restart_ic4",  32'(bus.ic4),  32'd0);
        wr_expect("t4_re_icw2", 1'b1, 8'h30, 1'b1, 1'b1, 2'd1);
        wr_expect("t4_re_icw3", 1'b1, 8'h00, 1'b1, 1'b1, 2'd2);
        check_val("t4_re_done", 32'(bus.init_done), 32'd1);

        // Reset in S_ICW2 with a write edge in flight
        wr_expect("t4_icw1b", 1'b0, 8'h13, 1'b1, 1'b1, 2'd0);
        p0 = pulse_cnt;
        @(negedge clk);
        bus.A0   = 1'b1;
        bus.din  = 8'h77;
        bus.CS_n = 1'b0;
        bus.WR_n = 1'b0;
        repeat (5) @(negedge clk);
        bus.WR_n = 1'b1;
        reset    = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state("t4_reset");
        reset    = 1'b0;
        bus.CS_n = 1'b1;
        bus.A0   = 1'b0;
        repeat (8) @(negedge clk);
        check_val("t4_reset_dropped", 32'(pulse_cnt - p0), 32'd0);
        check_val("t4_reset_init", 32'(bus.init_done), 32'd0);
        // Back in S_READY without init: A0=1 is a blocked OCW, not ICW2
        wr_expect("t4_after_reset", 1'b1, 8'h55, 1'b0, 1'b0, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
